// File: rtl/pll_pkg.sv
// Shared types and saturating arithmetic helpers for the PI loop filter.
// Helpers work on a 64-bit signed carrier; callers pass the target width.
package pll_pkg;

  typedef enum logic {ST_ACQUIRE = 1'b0, ST_TRACK = 1'b1} lock_state_e;

  typedef logic signed [63:0] wide_t;

  localparam wide_t ONE = 64'sd1;

  // sym=1 gives the symmetric range +/-(2^(w-1)-1); sym=0 the full two's-complement range.
  function automatic wide_t sat_clamp(input wide_t v, input int unsigned w, input logic sym);
    wide_t hi, lo;
    hi = (ONE <<< (w - 1)) - ONE;
    lo = sym ? -hi : -hi - ONE;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    return sat_clamp(a + b, w, 1'b1);
  endfunction

  function automatic wide_t abs_sat(input wide_t v, input int unsigned w);
    return sat_clamp((v < 0) ? -v : v, w, 1'b1);
  endfunction

endpackage

// File: rtl/pll_lock_detect.sv
// Lock detector: saturating |err|, consecutive-sample counter and ACQUIRE/TRACK FSM.
module pll_lock_detect
  import pll_pkg::*;
#(
  parameter int ERR_W      = 16,
  parameter int LOCK_THR   = 64,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_THR = 512,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    accept,
  input  logic                    clear,
  input  logic signed [ERR_W-1:0] err,
  output logic                    locked
);

  localparam int MAXC  = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CNT_W = $clog2(MAXC + 1);

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  wide_t            mag;
  logic             near, far;

  assign mag  = abs_sat(wide_t'(err), ERR_W);
  assign near = (mag <= wide_t'(LOCK_THR));
  assign far  = (mag >  wide_t'(UNLOCK_THR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ACQUIRE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    if (clear) begin
      state_d = ST_ACQUIRE;
      cnt_d   = '0;
    end else if (accept) begin
      case (state_q)
        ST_ACQUIRE: begin
          if (!near)                           cnt_d = '0;
          else if (cnt_inc == CNT_W'(LOCK_CNT)) begin state_d = ST_TRACK; cnt_d = '0; end
          else                                 cnt_d = cnt_inc;
        end
        ST_TRACK: begin
          if (!far)                              cnt_d = '0;
          else if (cnt_inc == CNT_W'(UNLOCK_CNT)) begin state_d = ST_ACQUIRE; cnt_d = '0; end
          else                                   cnt_d = cnt_inc;
        end
        default: begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign locked = (state_q == ST_TRACK);

endmodule

// File: rtl/pi_loop_filter.sv
// PI loop filter: BASE + proportional + integral path with saturation, gear-shifted
// gains selected by the lock detector state.
module pi_loop_filter
  import pll_pkg::*;
#(
  parameter int ERR_W      = 16,
  parameter int FCW_W      = 16,
  parameter int INT_W      = 32,
  parameter int INT_FRAC   = 16,
  parameter int BASE       = -262,
  parameter int KP_SH_ACQ  = 2,
  parameter int KP_SH_TRK  = 0,
  parameter int KI_SH_ACQ  = 4,
  parameter int KI_SH_TRK  = 0,
  parameter int LOCK_THR   = 64,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_THR = 512,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    err_valid,
  input  logic signed [ERR_W-1:0] phase_error,
  input  logic                    hold,
  input  logic                    clear,
  output logic signed [FCW_W-1:0] freq_control,
  output logic                    fcw_valid,
  output logic                    locked,
  output logic                    sat
);

  localparam logic signed [FCW_W-1:0] BASE_W = FCW_W'(BASE);

  logic signed [INT_W-1:0] integral_q;
  logic                    accept, locked_i;
  int                      kp_sh, ki_sh;
  wide_t                   err_w, sum, fcw_w, int_next;

  assign accept = err_valid & ~hold & ~clear;

  pll_lock_detect #(
    .ERR_W(ERR_W), .LOCK_THR(LOCK_THR), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_THR(UNLOCK_THR), .UNLOCK_CNT(UNLOCK_CNT)
  ) u_lock (
    .clk(clk), .reset_n(reset_n), .accept(accept), .clear(clear),
    .err(phase_error), .locked(locked_i)
  );

  // 64-bit carrier keeps every intermediate sum exact before the final clamp.
  always_comb begin
    err_w    = wide_t'(phase_error);
    kp_sh    = locked_i ? KP_SH_TRK : KP_SH_ACQ;
    ki_sh    = locked_i ? KI_SH_TRK : KI_SH_ACQ;
    sum      = wide_t'(BASE) + (err_w <<< kp_sh) + (wide_t'(integral_q) >>> INT_FRAC);
    fcw_w    = sat_clamp(sum, FCW_W, 1'b0);
    int_next = sat_add(wide_t'(integral_q), err_w <<< ki_sh, INT_W);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      integral_q   <= '0;
      freq_control <= BASE_W;
      sat          <= 1'b0;
      fcw_valid    <= 1'b0;
    end else if (clear) begin
      integral_q   <= '0;
      freq_control <= BASE_W;
      sat          <= 1'b0;
      fcw_valid    <= 1'b0;
    end else begin
      fcw_valid <= accept;
      if (accept) begin
        integral_q   <= int_next[INT_W-1:0];
        freq_control <= fcw_w[FCW_W-1:0];
        sat          <= (sum != fcw_w);
      end
    end
  end

  assign locked = locked_i;

endmodule

// File: tb/tb_pi_loop_filter.sv
// Directed and randomized bench for pi_loop_filter against an arithmetic reference model.
module tb_pi_loop_filter;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               err_valid = 1'b0;
  logic signed [15:0] phase_error = '0;
  logic               hold = 1'b0;
  logic               clear = 1'b0;
  logic signed [15:0] freq_control;
  logic               fcw_valid, locked, sat;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  longint m_int, m_fcw;
  bit     m_vld, m_sat, m_lock;
  int     m_cnt;

  localparam longint MAXI = 64'sd2147483647;

  always #5 clk = ~clk;

  pi_loop_filter dut (
    .clk(clk), .reset_n(reset_n), .err_valid(err_valid), .phase_error(phase_error),
    .hold(hold), .clear(clear), .freq_control(freq_control), .fcw_valid(fcw_valid),
    .locked(locked), .sat(sat)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint clampv(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic m_reset();
    m_int = 0; m_fcw = -262; m_vld = 0; m_sat = 0; m_lock = 0; m_cnt = 0;
  endtask

  task automatic m_step(input bit ev, input longint e, input bit h, input bit c);
    longint raw, a;
    int kp, ki;
    if (c) begin
      m_reset();
    end else if (ev && !h) begin
      kp    = m_lock ? 0 : 2;
      ki    = m_lock ? 0 : 4;
      raw   = -262 + e * (64'sd1 <<< kp) + (m_int >>> 16);
      m_fcw = clampv(raw, -32768, 32767);
      m_sat = (m_fcw != raw);
      m_vld = 1;
      a = (e < 0) ? -e : e;
      if (a > 32767) a = 32767;
      if (!m_lock) begin
        if (a <= 64) begin
          m_cnt++;
          if (m_cnt == 16) begin m_lock = 1; m_cnt = 0; end
        end else m_cnt = 0;
      end else begin
        if (a > 512) begin
          m_cnt++;
          if (m_cnt == 4) begin m_lock = 0; m_cnt = 0; end
        end else m_cnt = 0;
      end
      m_int = clampv(m_int + e * (64'sd1 <<< ki), -MAXI, MAXI);
    end else begin
      m_vld = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_fcw"},    freq_control, m_fcw);
    chk({tag, "_valid"},  fcw_valid,    m_vld);
    chk({tag, "_sat"},    sat,          m_sat);
    chk({tag, "_locked"}, locked,       m_lock);
  endtask

  task automatic step(input bit ev, input int e, input bit h, input bit c, input string tag);
    err_valid   = ev;
    phase_error = 16'(e);
    hold        = h;
    clear       = c;
    @(posedge clk);
    m_step(ev, longint'(e), h, c);
    #1;
    check_outs(tag);
  endtask

  function automatic int rand_err();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0, 1, 2, 3: return int'($urandom_range(0, 140)) - 70;
      4:          return int'($urandom_range(0, 1400)) - 700;
      5:          return int'($urandom_range(0, 65535)) - 32768;
      6: begin
        case ($urandom_range(0, 5))
          0: return 64;   1: return -65;  2: return 512;
          3: return -513; 4: return -32768; default: return 32767;
        endcase
      end
      default:    return 0;
    endcase
  endfunction

  logic signed [15:0] saved;

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    check_outs("rst");
    reset_n = 1'b1;
    repeat (5) step(0, 0, 0, 0, "idle");

    step(1, 100, 0, 0, "p1");
    chk("p1_fcw138", freq_control, 138);
    chk("p1_vld", fcw_valid, 1);
    step(1, 0, 0, 0, "p2");
    chk("p2_fcw_base", freq_control, -262);
    step(0, 0, 0, 0, "p3");
    chk("p3_vld_pulse", fcw_valid, 0);

    step(0, 0, 0, 1, "clr");
    repeat (4200) step(1, 32767, 0, 0, "posmax");
    chk("posmax_fcw", freq_control, 32767);
    chk("posmax_sat", sat, 1);
    step(1, 0, 0, 0, "posnowrap");
    chk("posnowrap_fcw", freq_control, 32505);
    step(0, 0, 0, 1, "clr");
    repeat (4200) step(1, -32768, 0, 0, "negmax");
    step(1, 0, 0, 0, "negnowrap");
    chk("negnowrap_fcw", freq_control, -32768);

    step(0, 0, 0, 1, "clr");
    repeat (15) step(1, 0, 0, 0, "acq");
    chk("acq15_locked", locked, 0);
    step(1, 0, 0, 0, "acq16");
    chk("acq16_locked", locked, 1);
    repeat (3) step(1, 1000, 0, 0, "far");
    chk("far3_locked", locked, 1);
    step(1, 1000, 0, 0, "far4");
    chk("far4_locked", locked, 0);
    repeat (16) step(1, 0, 0, 0, "relock");
    step(1, 1000, 0, 0, "gap"); step(1, 0, 0, 0, "gap"); step(1, 1000, 0, 0, "gap");
    chk("gap_locked", locked, 1);

    step(1, 1000, 0, 0, "hpre");
    saved = freq_control;
    repeat (3) step(1, 1000, 1, 0, "hold");
    chk("hold_fcw", freq_control, saved);
    chk("hold_vld", fcw_valid, 0);
    step(1, 1000, 0, 0, "hpost");
    chk("hpost_locked", locked, 1);

    step(1, 500, 0, 1, "clrtrk");
    chk("clrtrk_fcw", freq_control, -262);
    chk("clrtrk_locked", locked, 0);

    repeat (20) step(1, 30, 0, 0, "pre_rst");
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    m_reset();
    check_outs("midrst");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_err(), $urandom_range(0, 9) == 0,
           $urandom_range(0, 59) == 0, "rnd");
    end

    err_valid = 1'b0; hold = 1'b0; clear = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
